// File: rtl/axis_burst_tx_pkg.sv
// Shared definitions for the burst transmitter and its downstream wait block:
// FSM state encodings and the default stream geometry.
package axis_burst_tx_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } burst_state_t;

endpackage

// File: rtl/axis_tx_buf.sv
// Burst storage: DEPTH x WIDTH, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module axis_tx_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_burst_tx.sv
// Loads DEPTH words in IDLE, then on go requests the downstream block and
// streams the buffered words out as one AXI-stream burst with m_last.
// Handshake: a word transfers on a rising edge where m_valid and m_ready are
// both high; while m_valid is high and m_ready low, m_data/m_last/m_valid hold.
module axis_burst_tx
    import axis_burst_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             go,
    output logic             ex_start,
    input  logic             startAck,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             full,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    burst_state_t state, state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [WIDTH-1:0] rd_word;
    logic wr_fire, go_fire, xfer;

    assign full    = (count == FULL_CNT);
    assign wr_fire = (state == ST_IDLE) && wr_en && !full;
    assign go_fire = (state == ST_IDLE) && go && full;
    assign xfer    = (state == ST_SEND) && m_ready;

    axis_tx_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (wr_fire) begin
                count <= count + (AW + 1)'(1);
                // Pointers saturate at the last slot instead of wrapping.
                if (wr_ptr != LAST_PTR) wr_ptr <= wr_ptr + AW'(1);
            end
            if (xfer && rd_ptr != LAST_PTR) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (state == ST_DONE) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ex_start  = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = '0;
        done      = 1'b0;
        case (state)
            ST_IDLE: if (go_fire) state_nxt = ST_REQ;
            ST_REQ: begin
                ex_start = 1'b1;
                if (startAck) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                m_valid = 1'b1;
                m_data  = rd_word;
                m_last  = (rd_ptr == LAST_PTR);
                if (m_ready && m_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_axis_burst_tx.sv
// Directed bench for axis_burst_tx: load, launch, stream and reset scenarios
// with hand-computed expectations and an expected-word queue.
module tb_axis_burst_tx;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         go = 1'b0;
    logic         ex_start;
    logic         startAck = 1'b0;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         m_last;
    logic         full;
    logic         done;
    logic [1:0]   dbg_state;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    axis_burst_tx #(.WIDTH(W), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .go        (go),
        .ex_start  (ex_start),
        .startAck  (startAck),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .full      (full),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = W'(base + i);
            step();
        end
        wr_en = 1'b0;
    endtask

    // go, then startAck after ack_delay cycles of REQ; ends in the first SEND cycle.
    task automatic launch(input int ack_delay);
        go = 1'b1;
        step();
        go = 1'b0;
        for (int i = 0; i < ack_delay; i++) begin
            check("req_ex_start", W'(ex_start), 1);
            check("req_m_valid", W'(m_valid), 0);
            step();
        end
        check("ex_start_up", W'(ex_start), 1);
        startAck = 1'b1;
        step();
        startAck = 1'b0;
        check("ex_start_drop", W'(ex_start), 0);
        check("first_valid", W'(m_valid), 1);
    endtask

    task automatic receive(input int base, input int n_xfer, input bit toggle);
        int got = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [W-1:0] held = '0;
        logic [W-1:0] e;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(W'(base + i));
        while (got < n_xfer && cyc < 200) begin
            m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stalled) check("hold_data", m_data, held);
            if (m_valid && m_ready) begin
                e = exp_q.pop_front();
                check("word", m_data, e);
                check("last_flag", W'(m_last), W'(got == 7));
                got++;
                stalled = 0;
            end else if (m_valid) begin
                stalled = 1;
                held = m_data;
            end
            step();
            cyc++;
        end
        m_ready = 1'b0;
        check("xfer_count", W'(got), W'(n_xfer));
    endtask

    task automatic finish_burst();
        check("done_pulse", W'(done), 1);
        check("valid_after_last", W'(m_valid), 0);
        step();
        check("done_clear", W'(done), 0);
        check("full_clear", W'(full), 0);
        check("back_idle", W'(dbg_state), 0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_state", W'(dbg_state), 0);
        check("rst_full", W'(full), 0);
        check("rst_ex_start", W'(ex_start), 0);
        check("rst_m_valid", W'(m_valid), 0);
        check("rst_m_last", W'(m_last), 0);
        check("rst_done", W'(done), 0);
        check("rst_m_data", m_data, 0);
        rst = 1'b1;
        step();

        // Basic burst 0..7, m_ready held high
        load(0, 7);
        check("not_full_7", W'(full), 0);
        load(7, 1);
        check("full_8", W'(full), 1);
        launch(1);
        receive(0, 8, 1'b0);
        finish_burst();

        // m_ready toggling
        load(0, 8);
        launch(1);
        receive(0, 8, 1'b1);
        finish_burst();

        // go with partial buffer is ignored
        load(0, 5);
        check("partial_full", W'(full), 0);
        go = 1'b1;
        step();
        go = 1'b0;
        check("partial_go_ex", W'(ex_start), 0);
        check("partial_go_state", W'(dbg_state), 0);
        step();
        check("partial_go_ex2", W'(ex_start), 0);
        load(5, 3);
        check("partial_then_full", W'(full), 1);
        launch(0);
        receive(0, 8, 1'b0);
        finish_burst();

        // Ninth write discarded
        load(0, 9);
        check("ninth_full", W'(full), 1);
        launch(1);
        receive(0, 8, 1'b0);
        finish_burst();

        // go coinciding with the final write only completes the write
        load(20, 7);
        wr_en = 1'b1;
        wr_data = W'(27);
        go = 1'b1;
        step();
        wr_en = 1'b0;
        go = 1'b0;
        check("go_same_full", W'(full), 1);
        check("go_same_ex", W'(ex_start), 0);
        startAck = 1'b1;
        step();
        startAck = 1'b0;
        check("stray_ack_state", W'(dbg_state), 0);
        launch(1);
        receive(20, 8, 1'b0);
        finish_burst();

        // Long startAck delay
        load(0, 8);
        launch(20);
        receive(0, 8, 1'b0);
        finish_burst();

        // Reset mid-SEND abandons the burst
        load(0, 8);
        launch(1);
        receive(0, 3, 1'b0);
        rst = 1'b0;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        rst = 1'b1;
        check("midrst_valid", W'(m_valid), 0);
        check("midrst_full", W'(full), 0);
        check("midrst_state", W'(dbg_state), 0);
        check("midrst_data", m_data, 0);
        load(10, 8);
        launch(1);
        receive(10, 8, 1'b0);
        finish_burst();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_burst_tx.md
AXIS_BURST_TX -- requirements
Module: axis_burst_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 32, stream data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, words per burst (power of two, 2..256).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  buffer write strobe.
REQ-006 SHALL have port wr_data  input  WIDTH  buffer write word.
REQ-007 SHALL have port go  input  1  burst launch request.
REQ-008 SHALL have port ex_start  output  1  start request to the downstream wait block.
REQ-009 SHALL have port startAck  input  1  downstream acknowledge of ex_start.
REQ-010 SHALL have port m_data  output  WIDTH  AXI-stream master data.
REQ-011 SHALL have port m_valid  output  1  AXI-stream master valid.
REQ-012 SHALL have port m_ready  input  1  AXI-stream master ready.
REQ-013 SHALL have port m_last  output  1  high with the final burst word.
REQ-014 SHALL have port full  output  1  buffer holds DEPTH words.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last word transfers.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, SEND, DONE.
REQ-017 In IDLE, wr_en with full low SHALL write wr_data at write pointer and increment the pointer; full SHALL rise the cycle after the DEPTH-th write.
REQ-018 wr_en while full is high, or in any state other than IDLE, SHALL be ignored.
REQ-019 go sampled high in IDLE with full high SHALL move to REQ; ex_start SHALL be high on the next cycle.
REQ-020 go with full low, or outside IDLE, SHALL be ignored; go and the DEPTH-th wr_en in the same cycle SHALL complete the write only.
REQ-021 ex_start SHALL stay high throughout REQ; startAck sampled high in REQ SHALL move to SEND and drop ex_start the next cycle.
REQ-022 startAck outside REQ SHALL be ignored.
REQ-023 In SEND, m_valid SHALL be high with m_data = buffer[read pointer], starting the cycle after startAck is sampled.
REQ-024 m_data, m_last and m_valid SHALL be held stable while m_valid is high and m_ready is low.
REQ-025 A transfer (m_valid and m_ready both high) SHALL advance the read pointer by one; words SHALL leave in write order, back-to-back when m_ready stays high.
REQ-026 m_last SHALL be high only while read pointer = DEPTH-1.
REQ-027 The transfer of the m_last word SHALL move to DONE, with m_valid low the next cycle.
REQ-028 DONE SHALL last one cycle with done high, clear full and both pointers, then return to IDLE.
REQ-029 Pointers SHALL be log2(DEPTH) bits with no wrap-around beyond DEPTH; an explicit word counter of log2(DEPTH)+1 bits SHALL drive full.
REQ-030 Minimum burst time from go to done SHALL be DEPTH+3 cycles with immediate startAck and m_ready held high.

Reset
REQ-031 rst low at a rising edge SHALL force IDLE, pointers 0, full 0, ex_start 0, m_valid 0, m_last 0, done 0, m_data 0.
REQ-032 Reset in any state, including mid-SEND, SHALL abandon the burst; buffer contents SHALL be left uninitialised.
REQ-033 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-034 A shared header SHALL hold the FSM state encodings and the default WIDTH/DEPTH constants used by this block and the wait block.
REQ-035 Buffer storage SHALL be a sub-module axis_tx_buf (one write port, one asynchronous read port, DEPTH x WIDTH).
REQ-036 The FSM, pointers and handshake logic SHALL be in axis_burst_tx.

Verification
REQ-037 Write 0..7, go, startAck 1 cycle after ex_start, m_ready=1 -> m_data 0..7 on consecutive cycles, m_last with 7, done one cycle later, full=0.
REQ-038 Same load, m_ready toggled 1,0,1,0 -> each word held stable while m_ready=0, 8 transfers total, order 0..7.
REQ-039 go after only 5 writes -> ex_start stays 0; 3 more writes then go -> normal burst.
REQ-040 9 writes 0..8 -> full after 8th, word 8 discarded, burst emits 0..7.
REQ-041 startAck held 0 for 20 cycles -> ex_start high all 20 cycles, m_valid 0; startAck=1 -> burst proceeds.
REQ-042 rst low after 3rd transfer -> next cycle m_valid=0, full=0, IDLE; fresh load 10..17 and go -> emits 10..17.
